// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU (m0) and a debug/DMA requester (m1).
//   clk, rst             : clock, synchronous active-high reset
//   m0_ce/we/addr/wdata/sel -> m0_rdata, m0_stall : CPU data port; stalled when not granted
//   m1_req/we/addr/wdata/sel -> m1_gnt, m1_rvalid, m1_rdata : secondary requester, registered read return
//   mem_ce/we/addr/wdata/sel, mem_rdata : shared memory port (async read, write on clk edge)
//   The CPU normally wins. After STARVE_MAX denied m1 cycles, m1 gets up to BURST_MAX back-to-back grants.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_ce,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_sel,
    output logic [31:0] m0_rdata,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_sel,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel,
    input  logic [31:0] mem_rdata
);
    typedef enum logic {S_M0, S_M1} state_t;
    localparam logic [2:0] LP_STARVE = 3'(STARVE_MAX);
    localparam logic [2:0] LP_BURST  = 3'(BURST_MAX);
    state_t      r_state, w_state_nxt;
    logic [2:0]  r_starve, r_burst, w_starve_nxt, w_burst_nxt;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        w_g0, w_g1;
    // At most one of w_g0/w_g1 can be high; both are held low during reset.
    assign w_g0 = ~rst & m0_ce & (r_state == S_M0 | ~m1_req);
    assign w_g1 = ~rst & m1_req & (r_state == S_M1 | ~m0_ce);
    assign mem_ce    = w_g0 | w_g1;
    assign mem_we    = w_g0 ? m0_we    : w_g1 ? m1_we    : 1'b0;
    assign mem_addr  = w_g0 ? m0_addr  : w_g1 ? m1_addr  : 32'h0;
    assign mem_wdata = w_g0 ? m0_wdata : w_g1 ? m1_wdata : 32'h0;
    assign mem_sel   = w_g0 ? m0_sel   : w_g1 ? m1_sel   : 4'h0;
    assign m0_rdata  = mem_rdata;
    assign m0_stall  = ~rst & m0_ce & ~w_g0;
    assign m1_gnt    = w_g1;
    // The read return is forced quiet while reset is held, even if it was captured the edge before.
    assign m1_rvalid = r_rvalid & ~rst;
    assign m1_rdata  = rst ? 32'h0 : r_rdata;
    always_comb begin
        w_state_nxt  = r_state;
        w_burst_nxt  = r_burst;
        w_starve_nxt = w_g1 ? 3'd0 : (m1_req && r_starve != LP_STARVE) ? r_starve + 3'd1 : r_starve;
        if (r_state == S_M0) begin
            // Saturated counter still switches, so a request that vanished inside S_M1 is not lost.
            if (m1_req && !w_g1 && w_starve_nxt == LP_STARVE) begin
                w_state_nxt = S_M1;
                w_burst_nxt = 3'd0;
            end
        end else begin
            w_burst_nxt = (w_g1 && r_burst != LP_BURST) ? r_burst + 3'd1 : r_burst;
            if (!m1_req || w_burst_nxt == LP_BURST)
                w_state_nxt = S_M0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_M0;
            r_starve <= 3'd0;
            r_burst  <= 3'd0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_burst  <= w_burst_nxt;
            r_rvalid <= w_g1 & ~m1_we;
            if (w_g1 && !m1_we)
                r_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter (STARVE_MAX=4, BURST_MAX=2).
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_ce, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic        m0_stall, m1_gnt, m1_rvalid, mem_ce, mem_we;
    logic [3:0]  mem_sel;
    int          checks = 0;
    int          failures = 0;

    dmem_arbiter #(.STARVE_MAX(4), .BURST_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .m0_ce(m0_ce), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel),
        .m0_rdata(m0_rdata), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_ce = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_sel = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_sel = 0;
        mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        m0_ce = 1; m0_we = 1; m0_addr = 32'h44;
        m1_req = 1; m1_addr = 32'h88;
        mem_rdata = 32'h5555_AAAA;
        tick();
        tick();
        checks++;
        if ({mem_ce, mem_we, m1_gnt, m0_stall} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs ce/we/gnt/stall=%b expected 0000", {mem_ce, mem_we, m1_gnt, m0_stall});
        end
        checks++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_m1 rvalid=%b rdata=%h expected 0/00000000", m1_rvalid, m1_rdata);
        end
        rst = 0;
        idle();
        #1;
        checks++;
        if (mem_ce !== 1'b0 || mem_addr !== 32'h0 || mem_sel !== 4'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL idle_bus ce=%b addr=%h sel=%h wdata=%h expected all 0", mem_ce, mem_addr, mem_sel, mem_wdata);
        end
        tick();
    endtask

    task automatic test_m0_only();
        idle();
        m0_ce = 1;
        for (int i = 0; i < 10; i++) begin
            m0_we = i[0];
            m0_addr = 32'h1000 + 32'(i * 4);
            m0_wdata = 32'hA000_0000 | 32'(i);
            m0_sel = 4'hF;
            mem_rdata = 32'h0BAD_0000 + 32'(i);
            #1;
            checks++;
            if (mem_ce !== 1'b1 || m0_stall !== 1'b0 || m1_gnt !== 1'b0 || mem_addr !== 32'h1000 + 32'(i * 4)
                || mem_we !== i[0] || mem_wdata !== (32'hA000_0000 | 32'(i)) || m0_rdata !== 32'h0BAD_0000 + 32'(i)) begin
                failures++;
                $display("FAIL m0_only[%0d] ce=%b stall=%b gnt=%b addr=%h we=%b wdata=%h rdata=%h", i,
                         mem_ce, m0_stall, m1_gnt, mem_addr, mem_we, mem_wdata, m0_rdata);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_m1_read();
        idle();
        m1_req = 1; m1_addr = 32'h10; m1_sel = 4'hF;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m1_gnt !== 1'b1 || mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL m1_read_grant gnt=%b ce=%b we=%b addr=%h expected 1/1/0/00000010", m1_gnt, mem_ce, mem_we, mem_addr);
        end
        tick();
        idle();
        #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF || mem_ce !== 1'b0) begin
            failures++;
            $display("FAIL m1_read_return rvalid=%b rdata=%h ce=%b expected 1/deadbeef/0", m1_rvalid, m1_rdata, mem_ce);
        end
        tick();
        #1;
        checks++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL m1_read_after rvalid=%b rdata=%h expected 0/deadbeef", m1_rvalid, m1_rdata);
        end
    endtask

    task automatic test_m1_write();
        idle();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_sel = 4'b0011; m1_wdata = 32'h0000_ABCD;
        mem_rdata = 32'h1111_2222;
        #1;
        checks++;
        if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_sel !== 4'b0011 || mem_wdata !== 32'h0000_ABCD || mem_addr !== 32'h20) begin
            failures++;
            $display("FAIL m1_write gnt=%b we=%b sel=%b wdata=%h addr=%h expected 1/1/0011/0000abcd/00000020",
                     m1_gnt, mem_we, mem_sel, mem_wdata, mem_addr);
        end
        tick();
        idle();
        #1;
        checks++;
        if (m1_rvalid !== 1'b0 || mem_we !== 1'b0 || m1_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL m1_write_after rvalid=%b we=%b rdata=%h expected 0/0/deadbeef", m1_rvalid, mem_we, m1_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic exp1;
        idle();
        do_reset();
        m0_ce = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h200;
        for (int i = 0; i < 18; i++) begin
            exp1 = (i % 6) >= 4;
            #1;
            checks++;
            if (m1_gnt !== exp1 || m0_stall !== exp1 || mem_ce !== 1'b1 || mem_addr !== (exp1 ? 32'h200 : 32'h100)) begin
                failures++;
                $display("FAIL starve[%0d] gnt=%b stall=%b ce=%b addr=%h expected gnt=stall=%b", i,
                         m1_gnt, m0_stall, mem_ce, mem_addr, exp1);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_drop();
        idle();
        do_reset();
        m0_ce = 1; m0_addr = 32'h300;
        m1_req = 1; m1_we = 1; m1_addr = 32'h400;
        for (int i = 0; i < 4; i++) tick();
        #1;
        checks++;
        if (m1_gnt !== 1'b1 || m0_stall !== 1'b1) begin
            failures++;
            $display("FAIL drop_enter gnt=%b stall=%b expected 1/1", m1_gnt, m0_stall);
        end
        tick();
        m1_req = 0;
        #1;
        checks++;
        if (m1_gnt !== 1'b0 || m0_stall !== 1'b0 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL drop_m0 gnt=%b stall=%b addr=%h expected 0/0/00000300", m1_gnt, m0_stall, mem_addr);
        end
        tick();
        m1_req = 1;
        #1;
        checks++;
        if (m1_gnt !== 1'b0 || m0_stall !== 1'b0 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL drop_back_m0 gnt=%b stall=%b addr=%h expected 0/0/00000300", m1_gnt, m0_stall, mem_addr);
        end
        tick();
        idle();
    endtask

    task automatic test_rst_mid();
        idle();
        do_reset();
        m0_ce = 1; m0_addr = 32'h500;
        m1_req = 1; m1_addr = 32'h600;
        mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) tick();
        rst = 1;
        #1;
        checks++;
        if (m1_gnt !== 1'b0 || mem_ce !== 1'b0 || m0_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_forced gnt=%b ce=%b stall=%b expected 0/0/0", m1_gnt, mem_ce, m0_stall);
        end
        tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || m1_gnt !== (i == 4) || m0_stall !== (i == 4)) begin
                failures++;
                $display("FAIL rst_mid_after[%0d] rvalid=%b rdata=%h gnt=%b stall=%b expected 0/0/%b/%b", i,
                         m1_rvalid, m1_rdata, m1_gnt, m0_stall, i == 4, i == 4);
            end
            tick();
        end
        idle();
        m1_req = 1; m1_addr = 32'h700;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        idle();
        rst = 1;
        #1;
        checks++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_after_read rvalid=%b rdata=%h expected 0/00000000", m1_rvalid, m1_rdata);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_after_read_release rvalid=%b rdata=%h expected 0/00000000", m1_rvalid, m1_rdata);
        end
        tick();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_m0_only();
        test_m1_read();
        test_m1_write();
        test_starvation();
        test_drop();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive cycles m1 may be denied while requesting before m1 gets priority.
REQ-002 SHALL have parameter BURST_MAX, default 2: maximum consecutive m1 grants while m1 holds priority.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have ports m0_ce, m0_we  in  1: CPU data-port access enable and write enable.
REQ-006 SHALL have ports m0_addr, m0_wdata  in  32, and m0_sel  in  4: CPU address, write data and byte enables.
REQ-007 SHALL have ports m0_rdata  out  32 and m0_stall  out  1: CPU read data and hold-pipeline request.
REQ-008 SHALL have ports m1_req, m1_we  in  1, m1_addr, m1_wdata  in  32, and m1_sel  in  4: debug/DMA requester access.
REQ-009 SHALL have ports m1_gnt  out  1, m1_rvalid  out  1 and m1_rdata  out  32: m1 grant, registered read-valid and registered read data.
REQ-010 SHALL have ports mem_ce, mem_we  out  1, mem_addr, mem_wdata  out  32, and mem_sel  out  4, plus mem_rdata  in  32: shared dmem port (async read, write on clk edge).

Function
REQ-011 SHALL implement states S_M0 (CPU priority) and S_M1 (m1 priority), with 3-bit counters starve_cnt and burst_cnt.
REQ-012 In S_M0, SHALL grant m0 if m0_ce, else m1 if m1_req, else no one.
REQ-013 In S_M1, SHALL grant m1 if m1_req, else m0 if m0_ce, else no one.
REQ-014 Grant, mem_* outputs, m1_gnt and m0_stall SHALL be combinational in the same cycle as the request; the access completes that cycle (zero added latency for the granted master).
REQ-015 SHALL drive mem_ce=1 and the mem_* fields from the granted master; with no grant, mem_ce=0, mem_we=0 and mem_addr/mem_wdata/mem_sel=0.
REQ-016 SHALL set m0_stall = m0_ce AND NOT m0 granted, and m1_gnt = 1 only in a cycle where m1 is granted.
REQ-017 SHALL drive m0_rdata = mem_rdata continuously; it is meaningful only when m0 is granted with m0_we=0.
REQ-018 On an m1 read grant (m1_we=0), SHALL register m1_rdata <= mem_rdata and set m1_rvalid=1 for exactly the next cycle; m1 writes produce no m1_rvalid.
REQ-019 When m1_rvalid is not set, m1_rdata SHALL hold its last value.
REQ-020 starve_cnt SHALL increment by 1 each cycle m1_req=1 and m1 is not granted, and clear to 0 on any m1 grant.
REQ-021 S_M0->S_M1 SHALL occur when starve_cnt increments to STARVE_MAX; burst_cnt SHALL clear on entry to S_M1.
REQ-022 In S_M1, burst_cnt SHALL increment on each m1 grant.
REQ-023 S_M1->S_M0 SHALL occur after the grant that makes burst_cnt reach BURST_MAX, or in any S_M1 cycle with m1_req=0.
REQ-024 Counters SHALL never wrap: starve_cnt is bounded by STARVE_MAX and burst_cnt is bounded by BURST_MAX.
REQ-025 Simultaneous requests SHALL never produce both grants; exactly one master or neither is granted each cycle.

Reset
REQ-026 While rst=1: state SHALL be S_M0; starve_cnt, burst_cnt, m1_rvalid and m1_rdata SHALL be 0; mem_ce, mem_we, m1_gnt and m0_stall SHALL be forced to 0.
REQ-027 Reset asserted mid-burst or in the cycle after an m1 read grant SHALL suppress the pending m1_rvalid; the first cycle after rst deasserts SHALL behave as S_M0 with counters at 0.

Verification
REQ-028 m0_ce=1, m1_req=0 for 10 cycles -> mem_ce=1 every cycle, m0_stall=0, m1_gnt=0, state stays S_M0.
REQ-029 m0_ce=0, m1 read at addr 0x10, mem_rdata=0xDEADBEEF -> m1_gnt=1 same cycle; next cycle m1_rvalid=1 and m1_rdata=0xDEADBEEF; following cycle m1_rvalid=0.
REQ-030 m0_ce=1 and m1_req=1 held continuously from reset release -> grant pattern m0,m0,m0,m0,m1,m1 repeating; m0_stall=1 exactly in the m1 cycles.
REQ-031 Enter S_M1 via starvation, then drop m1_req after 1 grant -> next cycle returns to S_M0 and m0 is granted with m0_stall=0.
REQ-032 m1 write (sel=4'b0011, wdata=0x0000ABCD) granted -> mem_we=1, mem_sel=4'b0011, mem_wdata=0x0000ABCD for one cycle, m1_rvalid stays 0.
REQ-033 Assert rst in the cycle an m1 read is granted inside S_M1 -> the next cycle m1_rvalid=0, m1_rdata=0, state S_M0, starve_cnt=0, burst_cnt=0.
